// File: rtl/rate_tick_gen_if.sv
// Signal bundle between the rate tick generator and the block that uses it.
// The master drives enable and rate request. The slave (rate_tick_gen)
// returns the tick, the active rate and the change/pending flags.
// Optional square-wave output is present only when RATE_TICK_SQW_EN is defined.
interface rate_tick_gen_if #(
  parameter int SEL_W = 2
);

  logic             en;
  logic [SEL_W-1:0] sel_req;
  logic             tick;
  logic [SEL_W-1:0] sel_active;
  logic             sel_chg;
  logic             busy;
`ifdef RATE_TICK_SQW_EN
  logic             sqw;
`endif

`ifdef RATE_TICK_SQW_EN
  modport master (
    output en,
    output sel_req,
    input  tick,
    input  sel_active,
    input  sel_chg,
    input  busy,
    input  sqw
  );

  modport slave (
    input  en,
    input  sel_req,
    output tick,
    output sel_active,
    output sel_chg,
    output busy,
    output sqw
  );
`else
  modport master (
    output en,
    output sel_req,
    input  tick,
    input  sel_active,
    input  sel_chg,
    input  busy
  );

  modport slave (
    input  en,
    input  sel_req,
    output tick,
    output sel_active,
    output sel_chg,
    output busy
  );
`endif

endinterface

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: single-clock, glitch-free tick-enable generator with
// N_RATES selectable rates. Rate s has period BASE_DIV << (N_RATES-1-s)
// CLK cycles, so s=0 is the slowest rate. Rate changes requested while
// running are held off until the terminal count of the period in progress,
// so a period is never shortened or merged. While disabled the requested
// rate is adopted at once.
// Optional feature: define RATE_TICK_SQW_EN to add a registered 50% duty
// square wave output (sqw) at the active rate.
module rate_tick_gen #(
  parameter int N_RATES  = 4,
  parameter int SEL_W    = 2,
  parameter int BASE_DIV = 4,
  parameter int RST_SEL  = 0
) (
  input  logic          CLK,
  input  logic          RST_n,
  rate_tick_gen_if.slave bus
);

  localparam int P_MAX = BASE_DIV << (N_RATES - 1);
  localparam int CNT_W = $clog2(P_MAX);

  // Last count value of the period for rate s (P(s) - 1).
  function automatic logic [CNT_W-1:0] term_count(input logic [SEL_W-1:0] s);
    int shift;
    shift = N_RATES - 1 - int'(s);
    return CNT_W'((BASE_DIV << shift) - 1);
  endfunction

`ifdef RATE_TICK_SQW_EN
  // Count value at the end of the first (low) half of the period for rate s.
  function automatic logic [CNT_W-1:0] half_count(input logic [SEL_W-1:0] s);
    int shift;
    shift = N_RATES - 1 - int'(s);
    return CNT_W'(((BASE_DIV << shift) >> 1) - 1);
  endfunction
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sel_chg_q, sel_chg_d;
  logic [SEL_W-1:0] sel_active_q, sel_active_d;
`ifdef RATE_TICK_SQW_EN
  logic             sqw_q, sqw_d;
`endif

  logic [SEL_W-1:0] sel_clamped;
  logic [31:0]      sel_req_wide;
  logic             rate_diff;
  logic             at_term;

  // Out-of-range requests fold onto the fastest rate; widened compare keeps
  // the check meaningful when SEL_W cannot represent values >= N_RATES.
  always_comb begin
    sel_req_wide = {{(32-SEL_W){1'b0}}, bus.sel_req};
    if (sel_req_wide >= 32'(N_RATES)) begin
      sel_clamped = SEL_W'(N_RATES - 1);
    end else begin
      sel_clamped = bus.sel_req;
    end
  end

  assign rate_diff = (sel_clamped != sel_active_q);
  assign at_term   = (cnt_q == term_count(sel_active_q));

  // Next-state logic: disable clears and adopts the request immediately,
  // terminal count wraps, ticks and applies any pending rate change.
  always_comb begin
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    sel_chg_d    = 1'b0;
    sel_active_d = sel_active_q;
`ifdef RATE_TICK_SQW_EN
    sqw_d        = sqw_q;
`endif
    if (!bus.en) begin
      cnt_d        = '0;
      sel_active_d = sel_clamped;
      sel_chg_d    = rate_diff;
`ifdef RATE_TICK_SQW_EN
      sqw_d        = 1'b0;
`endif
    end else if (at_term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (rate_diff) begin
        sel_active_d = sel_clamped;
        sel_chg_d    = 1'b1;
      end
`ifdef RATE_TICK_SQW_EN
      // The high half ends here, so every period (old or new rate) restarts low.
      sqw_d = 1'b0;
`endif
    end else begin
      cnt_d = cnt_q + 1'b1;
`ifdef RATE_TICK_SQW_EN
      if (cnt_q == half_count(sel_active_q)) begin
        sqw_d = ~sqw_q;
      end
`endif
    end
  end

  // State registers; reset discards any partial period.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      sel_chg_q    <= 1'b0;
      sel_active_q <= SEL_W'(RST_SEL);
`ifdef RATE_TICK_SQW_EN
      sqw_q        <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      sel_chg_q    <= sel_chg_d;
      sel_active_q <= sel_active_d;
`ifdef RATE_TICK_SQW_EN
      sqw_q        <= sqw_d;
`endif
    end
  end

  assign bus.tick       = tick_q;
  assign bus.sel_chg    = sel_chg_q;
  assign bus.sel_active = sel_active_q;
  assign bus.busy       = rate_diff;
`ifdef RATE_TICK_SQW_EN
  assign bus.sqw        = sqw_q;
`endif

endmodule

// File: tb/tb_rate_tick_gen.sv
// Directed testbench for rate_tick_gen. Main instance uses the default
// parameters (periods 32/16/8/4); a second instance (N_RATES=3, BASE_DIV=2,
// RST_SEL=1, periods 8/4/2) exercises the clamp of sel_req=3.
// Inputs change and outputs are sampled on the falling edge of CLK.
module tb_rate_tick_gen;

  logic CLK;
  logic RST_n;
  int   n_compared;
  int   n_mismatched;

  rate_tick_gen_if #(.SEL_W(2)) bus ();
  rate_tick_gen_if #(.SEL_W(2)) bus_c ();

  rate_tick_gen #(
    .N_RATES(4), .SEL_W(2), .BASE_DIV(4), .RST_SEL(0)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .bus(bus)
  );

  rate_tick_gen #(
    .N_RATES(3), .SEL_W(2), .BASE_DIV(2), .RST_SEL(1)
  ) dut_c (
    .CLK(CLK), .RST_n(RST_n), .bus(bus_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reset values of both instances, and busy being live during reset.
  task automatic test_reset();
    RST_n = 1'b0;
    bus.en = 1'b0;
    bus.sel_req = 2'd0;
    bus_c.en = 1'b0;
    bus_c.sel_req = 2'd3;
    repeat (2) @(negedge CLK);
    n_compared++;
    if (bus.tick !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_tick: got %0b expected 0", bus.tick);
    end
    n_compared++;
    if (bus.sel_chg !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_sel_chg: got %0b expected 0", bus.sel_chg);
    end
    n_compared++;
    if (bus.sel_active !== 2'd0) begin
      n_mismatched++; $display("[TB] FAIL reset_sel_active: got %0d expected 0", bus.sel_active);
    end
    n_compared++;
    if (bus.busy !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy);
    end
    n_compared++;
    if (bus_c.sel_active !== 2'd1) begin
      n_mismatched++; $display("[TB] FAIL reset_c_sel_active: got %0d expected 1", bus_c.sel_active);
    end
    n_compared++;
    if (bus_c.busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL reset_c_busy_clamp: got %0b expected 1", bus_c.busy);
    end
    bus.sel_req = 2'd2;
    #1;
    n_compared++;
    if (bus.busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL reset_busy_req2: got %0b expected 1", bus.busy);
    end
    bus.sel_req = 2'd0;
    bus_c.sel_req = 2'd1;
    @(negedge CLK);
    RST_n = 1'b1;
  endtask

  // Slowest rate: tick every 32 cycles from en rising.
  task automatic test_steady_slow();
    logic exp_tick;
    bus.en = 1'b1;
    for (int i = 1; i <= 96; i++) begin
      @(negedge CLK);
      exp_tick = ((i % 32) == 0);
      n_compared++;
      if (bus.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL steady_tick c%0d: got %0b expected %0b", i, bus.tick, exp_tick);
      end
    end
    n_compared++;
    if (bus.sel_active !== 2'd0 || bus.busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL steady_state: got sel_active=%0d busy=%0b expected 0/0", bus.sel_active, bus.busy);
    end
    bus.en = 1'b0;
  endtask

  // 3 -> 1 request at cnt=1 is deferred to the 4-cycle terminal count.
  task automatic test_deferred_change();
    logic       exp_tick, exp_chg, exp_busy;
    logic [1:0] exp_sel;
    bus.sel_req = 2'd3;
    @(negedge CLK);
    n_compared++;
    if (bus.sel_active !== 2'd3 || bus.sel_chg !== 1'b1 || bus.tick !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL defer_setup: got sel=%0d chg=%0b tick=%0b expected 3/1/0", bus.sel_active, bus.sel_chg, bus.tick);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        bus.sel_req = 2'd1;
        #1;
      end
      exp_busy = (i >= 1 && i <= 3);
      exp_tick = (i == 4 || i == 20);
      exp_chg  = (i == 4);
      exp_sel  = (i >= 4) ? 2'd1 : 2'd3;
      n_compared++;
      if (bus.busy !== exp_busy) begin
        n_mismatched++; $display("[TB] FAIL defer_busy c%0d: got %0b expected %0b", i, bus.busy, exp_busy);
      end
      n_compared++;
      if (bus.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL defer_tick c%0d: got %0b expected %0b", i, bus.tick, exp_tick);
      end
      n_compared++;
      if (bus.sel_chg !== exp_chg) begin
        n_mismatched++; $display("[TB] FAIL defer_sel_chg c%0d: got %0b expected %0b", i, bus.sel_chg, exp_chg);
      end
      n_compared++;
      if (bus.sel_active !== exp_sel) begin
        n_mismatched++; $display("[TB] FAIL defer_sel_active c%0d: got %0d expected %0d", i, bus.sel_active, exp_sel);
      end
    end
    bus.en = 1'b0;
  endtask

  // 0 -> 2 -> 0 inside one slow period: no change, spacing stays 32.
  task automatic test_toggle_ignored();
    logic exp_tick, exp_busy;
    bus.sel_req = 2'd0;
    @(negedge CLK);
    n_compared++;
    if (bus.sel_active !== 2'd0 || bus.sel_chg !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL toggle_setup: got sel=%0d chg=%0b expected 0/1", bus.sel_active, bus.sel_chg);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK);
      if (i == 5) bus.sel_req = 2'd2;
      if (i == 12) bus.sel_req = 2'd0;
      #1;
      exp_tick = ((i % 32) == 0);
      exp_busy = (i >= 5 && i < 12);
      n_compared++;
      if (bus.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL toggle_tick c%0d: got %0b expected %0b", i, bus.tick, exp_tick);
      end
      n_compared++;
      if (bus.busy !== exp_busy) begin
        n_mismatched++; $display("[TB] FAIL toggle_busy c%0d: got %0b expected %0b", i, bus.busy, exp_busy);
      end
      n_compared++;
      if (bus.sel_chg !== 1'b0 || bus.sel_active !== 2'd0) begin
        n_mismatched++;
        $display("[TB] FAIL toggle_sel c%0d: got chg=%0b sel=%0d expected 0/0", i, bus.sel_chg, bus.sel_active);
      end
    end
  endtask

  // Disabled rate change is immediate; en dropped at terminal count gives no tick.
  task automatic test_disabled_change();
    logic exp_tick;
    bus.en = 1'b0;
    bus.sel_req = 2'd2;
    @(negedge CLK);
    n_compared++;
    if (bus.sel_active !== 2'd2 || bus.sel_chg !== 1'b1 || bus.tick !== 1'b0 || bus.busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL dis_change: got sel=%0d chg=%0b tick=%0b busy=%0b expected 2/1/0/0",
               bus.sel_active, bus.sel_chg, bus.tick, bus.busy);
    end
    @(negedge CLK);
    n_compared++;
    if (bus.sel_chg !== 1'b0 || bus.tick !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL dis_chg_single: got chg=%0b tick=%0b expected 0/0", bus.sel_chg, bus.tick);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      exp_tick = (i == 8);
      n_compared++;
      if (bus.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL dis_tick c%0d: got %0b expected %0b", i, bus.tick, exp_tick);
      end
      n_compared++;
      if (bus.sel_chg !== 1'b0) begin
        n_mismatched++; $display("[TB] FAIL dis_sel_chg c%0d: got %0b expected 0", i, bus.sel_chg);
      end
      if (i == 15) bus.en = 1'b0;
    end
  endtask

  // Reset at cnt=10 of a 16-cycle period, then restart at RST_SEL.
  task automatic test_reset_mid_period();
    logic exp_tick;
    bus.sel_req = 2'd1;
    @(negedge CLK);
    n_compared++;
    if (bus.sel_active !== 2'd1 || bus.sel_chg !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL rst_setup: got sel=%0d chg=%0b expected 1/1", bus.sel_active, bus.sel_chg);
    end
    bus.en = 1'b1;
    repeat (10) @(negedge CLK);
    RST_n = 1'b0;
    #1;
    n_compared++;
    if (bus.tick !== 1'b0 || bus.sel_chg !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_outputs: got tick=%0b chg=%0b expected 0/0", bus.tick, bus.sel_chg);
    end
    n_compared++;
    if (bus.sel_active !== 2'd0) begin
      n_mismatched++; $display("[TB] FAIL rst_mid_sel: got %0d expected 0", bus.sel_active);
    end
    n_compared++;
    if (bus.busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL rst_mid_busy: got %0b expected 1", bus.busy);
    end
    bus.en = 1'b0;
    bus.sel_req = 2'd0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    bus.en = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge CLK);
      exp_tick = (i == 32);
      n_compared++;
      if (bus.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL rst_restart_tick c%0d: got %0b expected %0b", i, bus.tick, exp_tick);
      end
    end
    bus.en = 1'b0;
  endtask

  // sel_req=3 on a 3-rate instance folds to rate 2 (P=2); then deferred change to 0 (P=8).
  task automatic test_clamp();
    logic       exp_tick, exp_chg;
    logic [1:0] exp_sel;
    bus_c.sel_req = 2'd3;
    #1;
    n_compared++;
    if (bus_c.busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL clamp_busy_pre: got %0b expected 1", bus_c.busy);
    end
    @(negedge CLK);
    n_compared++;
    if (bus_c.sel_active !== 2'd2 || bus_c.sel_chg !== 1'b1 || bus_c.busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL clamp_apply: got sel=%0d chg=%0b busy=%0b expected 2/1/0",
               bus_c.sel_active, bus_c.sel_chg, bus_c.busy);
    end
    bus_c.en = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      @(negedge CLK);
      exp_tick = (i <= 10) ? ((i % 2) == 0) : (i == 18);
      exp_chg  = (i == 10);
      exp_sel  = (i >= 10) ? 2'd0 : 2'd2;
      n_compared++;
      if (bus_c.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL clamp_tick c%0d: got %0b expected %0b", i, bus_c.tick, exp_tick);
      end
      n_compared++;
      if (bus_c.sel_chg !== exp_chg) begin
        n_mismatched++; $display("[TB] FAIL clamp_sel_chg c%0d: got %0b expected %0b", i, bus_c.sel_chg, exp_chg);
      end
      n_compared++;
      if (bus_c.sel_active !== exp_sel) begin
        n_mismatched++; $display("[TB] FAIL clamp_sel c%0d: got %0d expected %0d", i, bus_c.sel_active, exp_sel);
      end
      if (i == 8) bus_c.sel_req = 2'd0;
    end
    bus_c.en = 1'b0;
  endtask

`ifdef RATE_TICK_SQW_EN
  // Square wave at rate 2: 4 low, 4 high; forced low once en drops.
  task automatic test_sqw();
    logic exp_sqw, exp_tick;
    bus.sel_req = 2'd2;
    @(negedge CLK);
    n_compared++;
    if (bus.sqw !== 1'b0 || bus.sel_active !== 2'd2) begin
      n_mismatched++;
      $display("[TB] FAIL sqw_idle: got sqw=%0b sel=%0d expected 0/2", bus.sqw, bus.sel_active);
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge CLK);
      exp_sqw  = (i <= 21) ? ((i % 8) >= 4) : 1'b0;
      exp_tick = (i == 8 || i == 16);
      n_compared++;
      if (bus.sqw !== exp_sqw) begin
        n_mismatched++; $display("[TB] FAIL sqw_level c%0d: got %0b expected %0b", i, bus.sqw, exp_sqw);
      end
      n_compared++;
      if (bus.tick !== exp_tick) begin
        n_mismatched++; $display("[TB] FAIL sqw_tick c%0d: got %0b expected %0b", i, bus.tick, exp_tick);
      end
      if (i == 21) bus.en = 1'b0;
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_steady_slow();
    test_deferred_change();
    test_toggle_ignored();
    test_disabled_change();
    test_reset_mid_period();
    test_clamp();
`ifdef RATE_TICK_SQW_EN
    test_sqw();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
